weights_stream_loader: RTL and testbench

WEIGHTS_STREAM_LOADER -- requirements
Module: weights_stream_loader

---
 rtl/kws_weights_pkg.sv | 8 +
 rtl/weights_addr_counter.sv | 31 +++
 rtl/weights_stream_loader.sv | 71 +++++++
 tb/tb_weights_stream_loader.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/kws_weights_pkg.sv
// kws_weights_pkg: shared weight-matrix geometry, address width and loader state encoding
package kws_weights_pkg;
   localparam int ROWS = 20;
   localparam int COLS = 20;
   localparam int DW = 32;
   localparam int AW = 5;
   typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;
endpackage

// File: rtl/weights_addr_counter.sv
// weights_addr_counter: row-major raster counter with clear, increment, wrap and last-position flag
module weights_addr_counter
   import kws_weights_pkg::AW;
#(
   parameter int ROWS = kws_weights_pkg::ROWS,
   parameter int COLS = kws_weights_pkg::COLS
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [AW-1:0] row,
   output logic [AW-1:0] col,
   output logic          last
);
   logic col_end, row_end;
   assign col_end = col == AW'(COLS - 1);
   assign row_end = row == AW'(ROWS - 1);
   assign last = col_end && row_end;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (clr) begin
         row <= '0;
         col <= '0;
      end else if (inc) begin
         col <= col_end ? '0 : col + 1'b1;
         row <= !col_end ? row : row_end ? '0 : row + 1'b1;
      end
endmodule

// File: rtl/weights_stream_loader.sv
// weights_stream_loader: streams a row-major weight matrix into a register file, one registered write per accepted word
module weights_stream_loader
   import kws_weights_pkg::AW, kws_weights_pkg::state_t, kws_weights_pkg::IDLE,
          kws_weights_pkg::LOAD, kws_weights_pkg::FINISH;
#(
   parameter int ROWS = kws_weights_pkg::ROWS,
   parameter int COLS = kws_weights_pkg::COLS,
   parameter int DW = kws_weights_pkg::DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          s_valid,
   input  logic [DW-1:0] s_data,
   input  logic          s_last,
   output logic          s_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_row,
   output logic [AW-1:0] wr_col,
   output logic [DW-1:0] wr_data,
   output logic          busy,
   output logic          done,
   output logic          err
);
   state_t state;
   logic acc, clr, last;
   logic [AW-1:0] row, col;
   assign acc = s_valid && s_ready;
   assign clr = (state == IDLE) && start;
   weights_addr_counter #(.ROWS(ROWS), .COLS(COLS)) u_cnt (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(acc), .row(row), .col(col), .last(last)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         s_ready <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
         wr_en <= 1'b0;
         wr_row <= '0;
         wr_col <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= acc;
         done <= 1'b0;
         if (acc) begin
            wr_row <= row;
            wr_col <= col;
            wr_data <= s_data;
         end
         case (state)
            IDLE:
               if (start) begin
                  state <= LOAD;
                  s_ready <= 1'b1;
                  busy <= 1'b1;
                  err <= 1'b0;
               end
            LOAD:
               if (acc && (s_last || last)) begin
                  state <= FINISH;
                  s_ready <= 1'b0;
                  busy <= 1'b0;
                  done <= 1'b1;
                  if (s_last != last) err <= 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_weights_stream_loader.sv
// tb_weights_stream_loader: directed and randomized-valid loads checked against an arithmetic row-major write model
module tb_weights_stream_loader;
   localparam int ROWS = 20;
   localparam int COLS = 20;
   localparam int DW = 32;
   logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic s_ready, wr_en, busy, done, err;
   logic [4:0] wr_row, wr_col;
   logic [DW-1:0] wr_data;
   int checks = 0, failures = 0, viol = 0, done_cnt = 0;
   bit acc_prev = 1'b0;
   logic [42:0] wq[$];

   weights_stream_loader #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_last(s_last), .s_ready(s_ready), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
      .wr_data(wr_data), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en) wq.push_back({wr_row, wr_col, wr_data, done});
      if (wr_en && !acc_prev) viol++;
      if (done) done_cnt++;
      acc_prev = s_valid && s_ready;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic settle;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic send(input int first, input int last_word, input int last_at, input bit rnd, input int start_at);
      for (int k = first; k <= last_word; k++) begin
         bit acc;
         int guard;
         acc = 1'b0;
         guard = 0;
         while (!acc && guard < 64) begin
            s_valid = rnd ? 1'($urandom_range(1)) : 1'b1;
            s_data = DW'(k);
            s_last = (k == last_at);
            start = (k == start_at);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
         end
         if (!acc) begin
            chk("accept_timeout", 64'(guard), 64'(0));
            s_valid = 1'b0;
            s_last = 1'b0;
            return;
         end
      end
      s_valid = 1'b0;
      s_last = 1'b0;
   endtask

   task automatic verify(input string tag, input int n, input int done_idx);
      chk({tag, "_count"}, 64'(wq.size()), 64'(n));
      for (int k = 0; k < n && k < wq.size(); k++)
         chk(tag, 64'(wq[k]), 64'({5'(k / COLS), 5'(k % COLS), DW'(k), k == done_idx}));
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 chk("reset_outputs", 64'({s_ready, wr_en, busy, done, err, wr_row, wr_col, wr_data}), 64'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 s_valid = 1'b0;
      chk("idle_no_write", 64'(wq.size()), 64'(0));
      chk("idle_no_err", 64'({s_ready, busy, err}), 64'(0));

      wq.delete(); done_cnt = 0;
      do_start;
      chk("load_ready_busy", 64'({s_ready, busy}), 64'(2'b11));
      send(0, 399, 399, 1'b0, -1);
      settle;
      verify("full", 400, 399);
      chk("full_err", 64'(err), 64'(0));
      chk("full_done_cnt", 64'(done_cnt), 64'(1));
      chk("full_idle", 64'({s_ready, busy}), 64'(0));

      wq.delete(); done_cnt = 0; viol = 0;
      do_start;
      send(0, 399, 399, 1'b1, -1);
      settle;
      verify("rand", 400, 399);
      chk("rand_err", 64'(err), 64'(0));
      chk("rand_no_spurious_wr", 64'(viol), 64'(0));

      wq.delete(); done_cnt = 0;
      do_start;
      send(0, 57, 57, 1'b0, -1);
      chk("early_finish", 64'({done, wr_en, wr_row, wr_col, wr_data}), 64'({1'b1, 1'b1, 5'd2, 5'd17, DW'(57)}));
      s_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s_data = DW'(58 + i);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      settle;
      verify("early", 58, 57);
      chk("early_err", 64'(err), 64'(1));
      chk("early_idle", 64'({s_ready, busy}), 64'(0));
      chk("early_done_cnt", 64'(done_cnt), 64'(1));

      wq.delete(); done_cnt = 0;
      do_start;
      chk("start_clears_err_a", 64'(err), 64'(0));
      send(0, 399, -1, 1'b0, -1);
      settle;
      verify("nolast", 400, 399);
      chk("nolast_err", 64'(err), 64'(1));
      chk("nolast_done_cnt", 64'(done_cnt), 64'(1));

      wq.delete();
      do_start;
      chk("start_clears_err_b", 64'(err), 64'(0));
      send(0, 399, 399, 1'b0, 100);
      settle;
      verify("midstart", 400, 399);
      chk("midstart_word100", 64'(wq[100][42:33]), 64'({5'd5, 5'd0}));
      chk("midstart_err", 64'(err), 64'(0));

      wq.delete();
      do_start;
      send(0, 199, -1, 1'b0, -1);
      rst_n = 1'b0;
      s_valid = 1'b1;
      #1 chk("midreset_outputs", 64'({s_ready, wr_en, busy, done, err, wr_row, wr_col, wr_data}), 64'(0));
      repeat (3) @(posedge clk);
      #1 s_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      verify("partial", 199, -1);
      wq.delete(); done_cnt = 0;
      do_start;
      send(0, 399, 399, 1'b0, -1);
      settle;
      verify("restart", 400, 399);
      chk("restart_err", 64'(err), 64'(0));
      chk("no_spurious_wr", 64'(viol), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
